// File: rtl/i_stream_buffer.sv
// Single-entry next-line instruction stream buffer between the I-cache refill
// master and the memory read channel; prefetches line+1 after every refill.
module i_stream_buffer #(
    parameter int         BLOCK_OFFSET_WIDTH = 2,
    parameter logic [3:0] PF_ID              = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] cache_ar_addr,
    input  logic [7:0]  cache_ar_len,
    input  logic [3:0]  cache_ar_id,
    input  logic        cache_ar_valid,
    output logic        cache_ar_ready,
    output logic [31:0] cache_r_data,
    output logic        cache_r_valid,
    input  logic        cache_r_ready,
    output logic [25:0] mem_ar_addr,
    output logic [7:0]  mem_ar_len,
    output logic [3:0]  mem_ar_id,
    output logic        mem_ar_valid,
    input  logic        mem_ar_ready,
    input  logic [31:0] mem_r_data,
    input  logic        mem_r_valid,
    output logic        mem_r_ready
);
    // state    | meaning
    // IDLE     | accept a cache request, test it against the buffer
    // HIT_DATA | stream the buffered line to the cache
    // FWD_REQ  | demand miss: address phase to memory
    // FWD_DATA | demand miss: memory beats pass through and fill the buffer
    // PF_REQ   | next-line prefetch: address phase to memory
    // PF_DATA  | next-line prefetch: beats fill the buffer only

    localparam int ADDR_WIDTH = 26;
    localparam int DATA_WIDTH = 32;
    localparam int LINE_SIZE  = 1 << BLOCK_OFFSET_WIDTH;
    localparam int OFF_W      = BLOCK_OFFSET_WIDTH + 2;
    localparam int LINE_W     = ADDR_WIDTH - OFF_W;
    localparam logic [LINE_W-1:0]             LINE_ONE = LINE_W'(1);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] CNT_ONE  = BLOCK_OFFSET_WIDTH'(1);
    localparam logic [BLOCK_OFFSET_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE, HIT_DATA, FWD_REQ, FWD_DATA, PF_REQ, PF_DATA
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]         buf_data [LINE_SIZE];
    logic [LINE_W-1:0]             buf_line;
    logic                          buf_valid;
    logic [LINE_W-1:0]             r_line;
    logic [3:0]                    r_id;
    logic [BLOCK_OFFSET_WIDTH-1:0] cnt;

    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] pf_line;
    logic              cnt_last;
    logic              req_hit;
    logic              beat_in;
    logic              cnt_en;
    logic              unused_inputs;

    assign req_line = cache_ar_addr[ADDR_WIDTH-1:OFF_W];
    assign pf_line  = r_line + LINE_ONE;   // wraps to line 0 past the top
    assign cnt_last = (cnt == CNT_MAX);
    assign req_hit  = buf_valid && (req_line == buf_line);
    assign beat_in  = mem_r_valid && (state == FWD_DATA || state == PF_DATA);
    assign cnt_en   = (state == HIT_DATA) || beat_in;

    assign mem_ar_len    = 8'(LINE_SIZE);
    assign mem_r_ready   = 1'b1;
    assign unused_inputs = &{1'b0, cache_ar_len, cache_r_ready, cache_ar_addr[OFF_W-1:0]};

    always_comb begin
        state_next     = state;
        cache_ar_ready = 1'b0;
        cache_r_valid  = 1'b0;
        cache_r_data   = '0;
        mem_ar_valid   = 1'b0;
        mem_ar_addr    = '0;
        mem_ar_id      = PF_ID;
        case (state)
            IDLE: begin
                cache_ar_ready = 1'b1;
                if (cache_ar_valid) state_next = req_hit ? HIT_DATA : FWD_REQ;
            end
            HIT_DATA: begin
                cache_r_valid = 1'b1;
                cache_r_data  = buf_data[cnt];
                if (cnt_last) state_next = PF_REQ;
            end
            FWD_REQ: begin
                mem_ar_valid = 1'b1;
                mem_ar_addr  = {r_line, {OFF_W{1'b0}}};
                mem_ar_id    = r_id;
                if (mem_ar_ready) state_next = FWD_DATA;
            end
            FWD_DATA: begin
                cache_r_valid = mem_r_valid;
                cache_r_data  = mem_r_data;
                if (mem_r_valid && cnt_last) state_next = PF_REQ;
            end
            PF_REQ: begin
                mem_ar_valid = 1'b1;
                mem_ar_addr  = {pf_line, {OFF_W{1'b0}}};
                if (mem_ar_ready) state_next = PF_DATA;
            end
            PF_DATA: begin
                if (mem_r_valid && cnt_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_line  <= '0;
            r_line    <= '0;
            r_id      <= '0;
            cnt       <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && cache_ar_valid) begin
                r_line <= req_line;
                r_id   <= cache_ar_id;
            end
            if (state_next != state) cnt <= '0;
            else if (cnt_en)         cnt <= cnt + CNT_ONE;
            // the prefetch overwrites buf_data, so the old line is dead from here on
            if (state_next == PF_REQ && state != PF_REQ) begin
                buf_valid <= 1'b0;
            end else if (state == PF_DATA && mem_r_valid && cnt_last) begin
                buf_valid <= 1'b1;
                buf_line  <= pf_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_in) buf_data[cnt] <= mem_r_data;
    end

endmodule

// File: tb/tb_i_stream_buffer.sv
// Bench for i_stream_buffer: transaction-level buffer model plus a memory
// responder with programmable inter-beat gaps.
module tb_i_stream_buffer;
    localparam logic [3:0] PF_ID = 4'hE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] cache_ar_addr;
    logic [7:0]  cache_ar_len;
    logic [3:0]  cache_ar_id;
    logic        cache_ar_valid;
    logic        cache_ar_ready;
    logic [31:0] cache_r_data;
    logic        cache_r_valid;
    logic        cache_r_ready;
    logic [25:0] mem_ar_addr;
    logic [7:0]  mem_ar_len;
    logic [3:0]  mem_ar_id;
    logic        mem_ar_valid;
    logic        mem_ar_ready;
    logic [31:0] mem_r_data;
    logic        mem_r_valid;
    logic        mem_r_ready;

    always #5 clk = ~clk;

    i_stream_buffer #(.BLOCK_OFFSET_WIDTH(2), .PF_ID(PF_ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .cache_ar_addr(cache_ar_addr), .cache_ar_len(cache_ar_len),
        .cache_ar_id(cache_ar_id), .cache_ar_valid(cache_ar_valid),
        .cache_ar_ready(cache_ar_ready), .cache_r_data(cache_r_data),
        .cache_r_valid(cache_r_valid), .cache_r_ready(cache_r_ready),
        .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len), .mem_ar_id(mem_ar_id),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
        .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready)
    );

    typedef struct {
        logic [25:0] addr;
        logic [3:0]  id;
    } ar_t;

    ar_t         exp_ar[$];
    ar_t         ar_log[$];
    logic [31:0] exp_data[$];
    logic [31:0] data_log[$];
    logic [21:0] mem_q[$];
    logic [21:0] m_line;
    logic        m_valid;
    int gap = 0;
    int beats_seen = 0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [21:0] line, input int beat);
        if (line == 22'd4) return 32'hA0 + beat;
        return {8'hD0, line, beat[1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ar(input string name, input int idx, input logic [25:0] addr,
                            input logic [3:0] id);
        if (idx < ar_log.size()) begin
            check({name, "_addr"}, 32'(ar_log[idx].addr), 32'(addr));
            check({name, "_id"}, 32'(ar_log[idx].id), 32'(id));
        end else begin
            check({name, "_present"}, 32'(ar_log.size()), 32'(idx + 1));
        end
    endtask

    // Buffer model: a line is served locally only if it is the line prefetched last.
    function automatic void model_accept(input logic [25:0] a, input logic [3:0] id);
        logic [21:0] l;
        l = a[25:4];
        if (!(m_valid && m_line == l)) exp_ar.push_back('{addr: {l, 4'h0}, id: id});
        exp_ar.push_back('{addr: {l + 22'd1, 4'h0}, id: PF_ID});
        for (int i = 0; i < 4; i++) exp_data.push_back(mem_word(l, i));
        m_line  = l + 22'd1;
        m_valid = 1'b1;
    endfunction

    // memory responder: bursts in AR order, 'gap' idle cycles between beats
    initial begin
        int beat;
        int gap_left;
        beat = 0;
        gap_left = 0;
        mem_r_valid = 1'b0;
        mem_r_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_r_valid) begin
                beat++;
                if (beat == 4) begin
                    void'(mem_q.pop_front());
                    beat = 0;
                end
                gap_left = gap;
            end
            if (mem_q.size() > 0 && gap_left == 0) begin
                mem_r_valid = 1'b1;
                mem_r_data  = mem_word(mem_q[0], beat);
            end else begin
                mem_r_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rvalid_arvalid_exclusive", 32'(cache_r_valid && mem_ar_valid), 0);
                if (cache_r_valid) begin
                    beats_seen++;
                    data_log.push_back(cache_r_data);
                    check("r_beat_expected", 32'(exp_data.size() > 0), 1);
                    if (exp_data.size() > 0) check("r_data", cache_r_data, exp_data.pop_front());
                end
                if (mem_ar_valid && mem_ar_ready) begin
                    ar_log.push_back('{addr: mem_ar_addr, id: mem_ar_id});
                    mem_q.push_back(mem_ar_addr[25:4]);
                    check("ar_len", 32'(mem_ar_len), 32'd4);
                    check("ar_expected", 32'(exp_ar.size() > 0), 1);
                    if (exp_ar.size() > 0) begin
                        e = exp_ar.pop_front();
                        check("ar_addr", 32'(mem_ar_addr), 32'(e.addr));
                        check("ar_id", 32'(mem_ar_id), 32'(e.id));
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [25:0] a, input logic [3:0] id, output int waited);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cache_ar_addr  = a;
        cache_ar_id    = id;
        cache_ar_valid = 1'b1;
        forever begin
            @(negedge clk);
            check("ar_ready_only_when_mem_quiet", 32'(cache_ar_ready && mem_q.size() != 0), 0);
            if (cache_ar_ready || n >= 400) break;
            n++;
        end
        check("req_accepted", 32'(cache_ar_ready), 1);
        @(posedge clk);
        #1;
        cache_ar_valid = 1'b0;
        if (n < 400) model_accept(a, id);
        waited = n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((cache_ar_ready && mem_q.size() == 0 && !mem_r_valid) || n >= 600) break;
            n++;
        end
        check("idle_reached", 32'(n < 600), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int w;
        int n0;
        int b0;
        int n;
        cache_ar_addr  = '0;
        cache_ar_len   = 8'd4;
        cache_ar_id    = '0;
        cache_ar_valid = 1'b0;
        cache_r_ready  = 1'b1;
        mem_ar_ready   = 1'b1;
        m_valid        = 1'b0;
        m_line         = '0;

        #1;
        check("rst_ar_ready", 32'(cache_ar_ready), 1);
        check("rst_r_valid", 32'(cache_r_valid), 0);
        check("rst_mem_ar_valid", 32'(mem_ar_valid), 0);
        check("rst_mem_r_ready", 32'(mem_r_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // cold miss, with memory holding off ARREADY for three cycles
        mem_ar_ready = 1'b0;
        send_req(26'h000040, 4'h3, w);
        repeat (3) begin
            @(negedge clk);
            check("miss_ar_held", 32'(mem_ar_valid), 1);
            check("miss_ar_addr_held", 32'(mem_ar_addr), 32'h40);
        end
        @(posedge clk);
        #1 mem_ar_ready = 1'b1;
        wait_idle();
        check_ar("cold_fwd", 0, 26'h000040, 4'h3);
        check_ar("cold_pf", 1, 26'h000050, PF_ID);
        for (int i = 0; i < 4; i++)
            check("cold_data", (i < data_log.size()) ? data_log[i] : 32'hDEAD, 32'hA0 + i);

        // sequential hit: four back-to-back beats, no memory traffic, then prefetch
        send_req(26'h000050, 4'h4, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hit_r_valid", 32'(cache_r_valid), 1);
            check("hit_no_mem_ar", 32'(mem_ar_valid), 0);
        end
        @(negedge clk);
        check("hit_r_valid_done", 32'(cache_r_valid), 0);
        check("hit_pf_ar_valid", 32'(mem_ar_valid), 1);
        check("hit_pf_ar_addr", 32'(mem_ar_addr), 32'h60);
        check("hit_pf_ar_id", 32'(mem_ar_id), 32'(PF_ID));
        wait_idle();

        // non-sequential miss replaces the buffer; then its successor hits
        n0 = ar_log.size();
        send_req(26'h000100, 4'h5, w);
        wait_idle();
        check_ar("nonseq_fwd", n0, 26'h000100, 4'h5);
        check_ar("nonseq_pf", n0 + 1, 26'h000110, PF_ID);
        send_req(26'h000110, 4'h1, w);
        wait_idle();
        check("nonseq_hit_ar_count", 32'(ar_log.size()), 32'(n0 + 3));
        check_ar("nonseq_hit_pf", n0 + 2, 26'h000120, PF_ID);

        // request raised during a slow prefetch waits, then hits
        gap = 3;
        n0 = ar_log.size();
        send_req(26'h002000, 4'h6, w);
        n = 0;
        while (ar_log.size() < n0 + 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("pf_started", 32'(ar_log.size() >= n0 + 2), 1);
        send_req(26'h002010, 4'h7, w);
        check("pf_req_waited", 32'(w > 5), 1);
        wait_idle();
        check("pf_hit_ar_count", 32'(ar_log.size()), 32'(n0 + 3));
        check_ar("pf_hit_pf", n0 + 2, 26'h002020, PF_ID);
        gap = 0;

        // wrap of the top line; offset bits of the request are ignored
        n0 = ar_log.size();
        send_req(26'h3FFFFFC, 4'h8, w);
        wait_idle();
        check_ar("wrap_fwd", n0, 26'h3FFFFF0, 4'h8);
        check_ar("wrap_pf", n0 + 1, 26'h0000000, PF_ID);

        // asynchronous reset while the third demand beat is on the bus
        gap = 3;
        b0 = beats_seen;
        send_req(26'h003000, 4'h9, w);
        n = 0;
        while (beats_seen < b0 + 2 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_two_beats_seen", 32'(beats_seen - b0), 2);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!mem_r_valid && n < 300);
        @(negedge clk);
        #2;
        check("fwd_beat3_before_reset", 32'(cache_r_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_r_valid", 32'(cache_r_valid), 0);
        check("arst_mem_ar_valid", 32'(mem_ar_valid), 0);
        check("arst_ar_ready", 32'(cache_ar_ready), 1);
        exp_data.delete();
        exp_ar.delete();
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        gap = 0;
        wait_idle();
        n0 = ar_log.size();
        send_req(26'h003000, 4'hA, w);
        wait_idle();
        check_ar("post_rst_fwd", n0, 26'h003000, 4'hA);
        check_ar("post_rst_pf", n0 + 1, 26'h003010, PF_ID);

        check("exp_data_drained", 32'(exp_data.size()), 0);
        check("exp_ar_drained", 32'(exp_ar.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
